// File: rtl/dla_reset_sequencer.sv
// Staged reset release sequencer: hold all stage resets, then release them one
// at a time, lowest stage first, with a software-triggered re-sequence path.
//
// Ports:
//   clk              - single clock, rising edge
//   i_async_resetn   - async-assert / sync-deassert active-low reset
//   i_sw_reset_req   - level request for a software reset sequence (RUN only)
//   o_sw_reset_ack   - one-cycle pulse when a software sequence completes
//   o_resetn         - per-stage active-low resets, thermometer from bit 0
//   o_all_released   - high when every o_resetn bit is high
module dla_reset_sequencer #(
  parameter int NUM_STAGES  = 3,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  i_async_resetn,
  input  logic                  i_sw_reset_req,
  output logic                  o_sw_reset_ack,
  output logic [NUM_STAGES-1:0] o_resetn,
  output logic                  o_all_released
);

  localparam int MAXC = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int IW   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] LAST     = IW'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic            rel;
  logic            pend, pend_nx;
  logic [NUM_STAGES-1:0] rstn_nx;
  logic            all_nx;
  logic            ack_nx;

  // State, counter and registered outputs
  always_ff @(posedge clk or negedge i_async_resetn) begin
    if (!i_async_resetn) begin
      state          <= HOLD;
      cnt            <= '0;
      idx            <= '0;
      pend           <= 1'b0;
      o_resetn       <= '0;
      o_all_released <= 1'b0;
      o_sw_reset_ack <= 1'b0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      idx            <= idx_nx;
      pend           <= pend_nx;
      o_resetn       <= rstn_nx;
      o_all_released <= all_nx;
      o_sw_reset_ack <= ack_nx;
    end
  end

  // Next-state: idx is the most recently released stage
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    rel      = 1'b0;
    unique case (state)
      HOLD: begin
        if (cnt == HOLD_END) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          rel      = 1'b1;
          state_nx = (NUM_STAGES == 1) ? RUN : RELEASE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == GAP_END) begin
          cnt_nx = '0;
          idx_nx = idx + 1'b1;
          rel    = 1'b1;
          if (idx_nx == LAST) state_nx = RUN;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (i_sw_reset_req) begin
          state_nx = HOLD;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = HOLD;
        cnt_nx   = '0;
        idx_nx   = '0;
      end
    endcase
  end

  // Output values loaded on the next edge
  always_comb begin
    rstn_nx = o_resetn;
    ack_nx  = 1'b0;
    pend_nx = pend;
    if (state == RUN && i_sw_reset_req) begin
      rstn_nx = '0;
      pend_nx = 1'b1;
    end else if (rel) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (IW'(i) == idx_nx) rstn_nx[i] = 1'b1;
      end
    end
    // Ack fires on the RUN entry edge only
    if (pend && state != RUN && state_nx == RUN) begin
      ack_nx  = 1'b1;
      pend_nx = 1'b0;
    end
    all_nx = &rstn_nx;
  end

endmodule

// File: tb/tb_dla_reset_sequencer.sv
// Directed bench for dla_reset_sequencer: default build plus a 1/1/1 build.
// Edge-numbered vector tables with hand-derived expected outputs.
module tb_dla_reset_sequencer;

  logic       clk;
  logic       rst;
  logic       req;
  logic       ack;
  logic [2:0] rn;
  logic       all;

  logic       rst1;
  logic       req1;
  logic       ack1;
  logic [0:0] rn1;
  logic       all1;

  int total;
  int bad;
  int ecount;

  dla_reset_sequencer dut (
    .clk            (clk),
    .i_async_resetn (rst),
    .i_sw_reset_req (req),
    .o_sw_reset_ack (ack),
    .o_resetn       (rn),
    .o_all_released (all)
  );

  dla_reset_sequencer #(
    .NUM_STAGES  (1),
    .HOLD_CYCLES (1),
    .STAGE_GAP   (1)
  ) dut1 (
    .clk            (clk),
    .i_async_resetn (rst1),
    .i_sw_reset_req (req1),
    .o_sw_reset_ack (ack1),
    .o_resetn       (rn1),
    .o_all_released (all1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         e;
    logic       r;
    logic [4:0] x;
  } vec_t;

  vec_t tv[24];
  int   nv;

  task automatic add(input int e, input logic r,
                     input logic [2:0] n, input logic a, input logic k);
    tv[nv].e = e;
    tv[nv].r = r;
    tv[nv].x = {n, a, k};
    nv++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic cmp(input string nm, input logic [4:0] act,
                     input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rn/all/ack=%b want %b", nm, act, exp);
    end
  endtask

  task automatic run(input int lo, input int hi, input string tag);
    int base;
    base = ecount;
    for (int i = lo; i < hi; i++) begin
      while (ecount - base < tv[i].e) tick();
      cmp($sformatf("%s e%0d", tag, tv[i].e), {rn, all, ack}, tv[i].x);
      req = tv[i].r;
    end
  endtask

  task automatic deassert();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int base;
    total  = 0;
    bad    = 0;
    ecount = 0;
    nv     = 0;
    rst    = 1'b0;
    req    = 1'b0;
    rst1   = 1'b0;
    req1   = 1'b0;

    // Power-on: sw pulse on edges 5..8 is ignored in HOLD
    add(4,  1'b1, 3'b000, 1'b0, 1'b0);
    add(8,  1'b0, 3'b000, 1'b0, 1'b0);
    add(15, 1'b0, 3'b000, 1'b0, 1'b0);
    add(16, 1'b0, 3'b001, 1'b0, 1'b0);
    add(19, 1'b0, 3'b001, 1'b0, 1'b0);
    add(20, 1'b0, 3'b011, 1'b0, 1'b0);
    add(23, 1'b0, 3'b011, 1'b0, 1'b0);
    add(24, 1'b0, 3'b111, 1'b1, 1'b0);
    add(25, 1'b0, 3'b111, 1'b1, 1'b0);
    add(30, 1'b0, 3'b111, 1'b1, 1'b0);
    // Software sequence, request raised just after edge 0
    add(1,  1'b1, 3'b000, 1'b0, 1'b0);
    add(16, 1'b1, 3'b000, 1'b0, 1'b0);
    add(17, 1'b1, 3'b001, 1'b0, 1'b0);
    add(21, 1'b1, 3'b011, 1'b0, 1'b0);
    add(24, 1'b1, 3'b011, 1'b0, 1'b0);
    add(25, 1'b0, 3'b111, 1'b1, 1'b1);
    add(26, 1'b0, 3'b111, 1'b1, 1'b0);
    add(30, 1'b0, 3'b111, 1'b1, 1'b0);

    #2;
    cmp("reset state", {rn, all, ack}, 5'b00000);
    cmp("reset state s1", {2'b00, rn1, all1, ack1}, 5'b00000);

    deassert();
    run(0, 10, "por");

    req = 1'b1;
    run(10, 18, "sw");

    // Abort mid-release at edge 22
    rst = 1'b0;
    #1;
    cmp("abort reset", {rn, all, ack}, 5'b00000);
    deassert();
    base = ecount;
    while (ecount - base < 22) tick();
    cmp("mid e22", {rn, all, ack}, 5'b01100);
    #2;
    rst = 1'b0;
    #1;
    cmp("async clr", {rn, all, ack}, 5'b00000);
    deassert();
    run(0, 10, "por2");

    // Abort mid software sequence: no ack afterwards
    req = 1'b1;
    base = ecount;
    while (ecount - base < 10) tick();
    cmp("sw e10", {rn, all, ack}, 5'b00000);
    #2;
    rst = 1'b0;
    req = 1'b0;
    #1;
    cmp("sw abort", {rn, all, ack}, 5'b00000);
    deassert();
    run(0, 10, "por3");

    // Minimal build: 1 stage, 1-cycle hold and gap
    @(negedge clk);
    rst1 = 1'b1;
    tick();
    cmp("s1 e1", {2'b00, rn1, all1, ack1}, 5'b00110);
    req1 = 1'b1;
    tick();
    cmp("s1 sw low", {2'b00, rn1, all1, ack1}, 5'b00000);
    tick();
    cmp("s1 sw ack", {2'b00, rn1, all1, ack1}, 5'b00111);
    tick();
    cmp("s1 req held", {2'b00, rn1, all1, ack1}, 5'b00000);
    req1 = 1'b0;
    tick();
    cmp("s1 ack2", {2'b00, rn1, all1, ack1}, 5'b00111);
    tick();
    cmp("s1 run", {2'b00, rn1, all1, ack1}, 5'b00110);
    cmp("main idle", {rn, all, ack}, 5'b11110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
